nibble_serial_addsub: RTL
=========================

Name: nibble_serial_addsub

Overview:
- Multi-cycle adder/subtractor for wide operands. Processes one 4-bit nibble per clock, using internal propagate/generate and 4-bit lookahead carry logic.
- Holds the nibble carry-out in a flop and feeds it forward as the carry-in of the next nibble.
- Sits between the operand source and the result consumer. Uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4.
- NIB (derived, not overridable), WIDTH/4, number of RUN cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  operand source has a valid request
- start_ready  output  1  block can accept a request (high only in IDLE)
- a  input  WIDTH  operand A, sampled only at accept
- b  input  WIDTH  operand B, sampled only at accept
- sub  input  1  0 = A+B, 1 = A-B; sampled only at accept
- result_valid  output  1  sum/cout/overflow are valid
- result_ready  input  1  consumer takes the result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB; for sub, 1 = no borrow
- overflow  output  1  two's-complement overflow
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst_n low): state=IDLE; sum=0, cout=0, overflow=0, result_valid=0, busy=0; internal carry, index, operand regs=0. start_ready=1 while in IDLE after reset. Reset in RUN or DONE aborts the operation with no partial result.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&start_ready at an edge: latch A, latch B' = b XOR {WIDTH{sub}}, set carry=sub, nibble index=0, go to RUN.
- RUN, each cycle for index k:
  - p = A[k] ^ B'[k], g = A[k] & B'[k].
  - Carries c0..c3 by full lookahead from carry (no ripple within a nibble).
  - sum nibble k = p ^ {c2,c1,c0,carry}. Write it into sum[4k+3:4k] and set carry<=c3.
  - On the last nibble (k=NIB-1): cout<=c3, overflow<=c2^c3 (carry into MSB XOR carry out), go to DONE.
  - Changes on a/b/sub during RUN are ignored.
- Latency: accept edge T0; RUN occupies edges T1..T_NIB; result_valid is high after edge T_NIB (4 cycles for WIDTH=16). Throughput is one operation per NIB+2 cycles when the consumer is always ready.
- DONE:
  - result_valid=1. sum, cout and overflow stay stable until result_valid&result_ready.
  - On that handshake edge: go to IDLE and drop result_valid.
  - start_ready=0 throughout DONE, so start_valid in the same cycle as result_ready is not accepted; it is accepted on the next cycle, in IDLE.
- sum, cout and overflow keep their last values in IDLE; they are meaningful only while result_valid=1.
- Partial sum nibbles may change during RUN. The consumer must not sample sum unless result_valid=1.
- Wrap-around: the result is modulo 2^WIDTH. The carry out of the MSB is reported only on cout.
- busy = (state != IDLE).

Test Plan:
- 0x00FF + 0x0001, sub=0 -> sum=0x0100, cout=0, overflow=0; result_valid rises exactly 4 cycles after the accept edge.
- 0xFFFF + 0x0001, sub=0 -> sum=0x0000, cout=1, overflow=0 (carry crosses all 4 nibble boundaries via the carry flop).
- 0x7FFF + 0x0001, sub=0 -> sum=0x8000, cout=0, overflow=1.
- 0x0003 - 0x0005 -> sum=0xFFFE, cout=0, overflow=0; then 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, overflow=1.
- Backpressure: hold result_ready=0 for 5 cycles in DONE with start_valid=1 and a/b toggling -> outputs frozen, start_ready=0, no new accept. Raise result_ready -> IDLE next edge, and the pending request is accepted one cycle later.
- Assert rst_n=0 after 2 RUN cycles -> all outputs 0 immediately, start_ready=1. Then 0x1234 + 0x1111 -> sum=0x2345, cout=0, overflow=0.

Source files
------------

// File: rtl/nibble_serial_addsub.sv
// Nibble-serial adder/subtractor: one 4-bit lookahead slice per clock,
// with the slice carry held in a flop between nibbles.
module nibble_serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             rv_q;

    logic [3:0] an;
    logic [3:0] bn;
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;
    logic [3:0] sn;
    logic       last;

    always_comb begin
        an = a_q[4*int'(idx_q) +: 4];
        bn = b_q[4*int'(idx_q) +: 4];
        p  = an ^ bn;
        g  = an & bn;
        // Flat lookahead: every carry comes straight from carry_q
        c[0] = g[0] | (p[0] & carry_q);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & carry_q);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & carry_q);
        sn    = p ^ {c[2:0], carry_q};
        sum_d = sum_q;
        sum_d[4*int'(idx_q) +: 4] = sn;
        last  = (int'(idx_q) == NIB - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= sub;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= c[3];
                    idx_q   <= idx_q + 1'b1;
                    if (last) begin
                        cout_q  <= c[3];
                        ovf_q   <= c[2] ^ c[3];
                        rv_q    <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        rv_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start_ready  = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign result_valid = rv_q;
    assign sum          = sum_q;
    assign cout         = cout_q;
    assign overflow     = ovf_q;

endmodule
